// File: rtl/rotate_func.sv
// Rho step over a 25-lane x 64-bit state stored as 64 slices of 25 bits.
// It loads all 64 slices, then writes each slice back with its lanes rotated by fixed offsets.
module rotate_func (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [24:0] line_in,
    output logic [6:0]  cnt_value,
    output logic        write_enable,
    output logic [24:0] write_value,
    output logic        donee
);

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        WRITE,
        DONE
    } state_t;

    localparam logic [5:0] ROT [25] = '{
        6'd0,  6'd1,  6'd62, 6'd28, 6'd27,
        6'd36, 6'd44, 6'd6,  6'd55, 6'd20,
        6'd3,  6'd10, 6'd43, 6'd25, 6'd39,
        6'd41, 6'd45, 6'd15, 6'd21, 6'd8,
        6'd18, 6'd2,  6'd61, 6'd56, 6'd14
    };

    state_t      state;
    state_t      state_next;
    logic [5:0]  cnt;
    logic [5:0]  cnt_next;
    logic [24:0] slices [64];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
        end
    end

    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        case (state)
            IDLE: begin
                if (start) begin
                    state_next = LOAD;
                    cnt_next   = '0;
                end
            end
            LOAD: begin
                cnt_next = cnt + 6'd1;
                if (cnt == 6'd63) begin
                    state_next = WRITE;
                end
            end
            WRITE: begin
                cnt_next = cnt + 6'd1;
                if (cnt == 6'd63) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Slice buffer carries no reset: every pass overwrites all 64 entries before reading.
    always_ff @(posedge clk) begin
        if (state == LOAD) begin
            slices[cnt] <= line_in;
        end
    end

    always_comb begin
        cnt_value    = '0;
        write_enable = 1'b0;
        donee        = 1'b0;
        if (state == LOAD || state == WRITE) begin
            cnt_value = {1'b0, cnt};
        end
        if (state == WRITE) begin
            write_enable = 1'b1;
        end
        if (state == DONE) begin
            donee = 1'b1;
        end
    end

    // Lane i of output slice z comes from lane i of buffered slice (z - r[i]) mod 64.
    always_comb begin
        logic [5:0] src;
        src         = '0;
        write_value = '0;
        if (state == WRITE) begin
            for (int unsigned i = 0; i < 25; i++) begin
                src            = cnt - ROT[i];
                write_value[i] = slices[src][i];
            end
        end
    end

endmodule

// File: tb/tb_rotate_func.sv
// Randomized and directed checks of rotate_func against a lane-rotation reference model.
// Memory is a read-only array presented combinationally at cnt_value.
module tb_rotate_func;

    logic        clk;
    logic        rst;
    logic        start;
    logic [24:0] line_in;
    logic [6:0]  cnt_value;
    logic        write_enable;
    logic [24:0] write_value;
    logic        donee;

    logic [24:0] mem       [64];
    logic [24:0] exp_slice [64];

    int checks;
    int errors;

    int rot_tab [25] = '{0, 1, 62, 28, 27, 36, 44, 6, 55, 20, 3, 10, 43, 25, 39,
                         41, 45, 15, 21, 8, 18, 2, 61, 56, 14};

    rotate_func dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .line_in     (line_in),
        .cnt_value   (cnt_value),
        .write_enable(write_enable),
        .write_value (write_value),
        .donee       (donee)
    );

    assign line_in = mem[cnt_value[5:0]];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #3ms;
        $display("FAIL timeout: got no finish want finish");
        $fatal(1, "timeout");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %0h want %0h", tag, got, want);
        end
    endtask

    // Reference: gather each lane as a 64-bit word, rotate left by its offset, scatter back.
    task automatic compute_expected();
        logic [63:0] lane;
        for (int i = 0; i < 25; i++) begin
            for (int z = 0; z < 64; z++) lane[z] = mem[z][i];
            lane = (lane << rot_tab[i]) | (lane >> (64 - rot_tab[i]));
            for (int z = 0; z < 64; z++) exp_slice[z][i] = lane[z];
        end
    endtask

    task automatic fill_zero();
        for (int z = 0; z < 64; z++) mem[z] = '0;
    endtask

    task automatic fill_random();
        for (int z = 0; z < 64; z++) mem[z] = 25'($urandom);
    endtask

    task automatic check_idle(input string tag);
        check({tag, "_we"}, {31'd0, write_enable}, 32'd0);
        check({tag, "_cnt"}, {25'd0, cnt_value}, 32'd0);
        check({tag, "_done"}, {31'd0, donee}, 32'd0);
        check({tag, "_wv"}, {7'd0, write_value}, 32'd0);
    endtask

    // One pass: start sampled at edge E0, cycle k is the interval after edge E0+k-1... sampled at negedge.
    task automatic run_pass(input string name, input bit extra, input int abort_at, input bit hold);
        compute_expected();
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1;
        if (!hold) start = 1'b0;
        for (int cyc = 1; cyc <= 129; cyc++) begin
            @(negedge clk);
            if (extra && cyc == 31) start = 1'b0;
            if (cyc <= 64) begin
                check($sformatf("%s_load_we_%0d", name, cyc), {31'd0, write_enable}, 32'd0);
                check($sformatf("%s_load_cnt_%0d", name, cyc), {25'd0, cnt_value}, 32'(cyc - 1));
                check($sformatf("%s_load_wv_%0d", name, cyc), {7'd0, write_value}, 32'd0);
            end else if (cyc <= 128) begin
                check($sformatf("%s_wr_we_%0d", name, cyc), {31'd0, write_enable}, 32'd1);
                check($sformatf("%s_wr_cnt_%0d", name, cyc), {25'd0, cnt_value}, 32'(cyc - 65));
                check($sformatf("%s_wr_val_%0d", name, cyc - 65), {7'd0, write_value},
                      {7'd0, exp_slice[cyc - 65]});
                check($sformatf("%s_wr_done_%0d", name, cyc), {31'd0, donee}, 32'd0);
            end else begin
                check($sformatf("%s_done", name), {31'd0, donee}, 32'd1);
                check($sformatf("%s_done_we", name), {31'd0, write_enable}, 32'd0);
                check($sformatf("%s_done_cnt", name), {25'd0, cnt_value}, 32'd0);
            end
            if (extra && cyc == 30) start = 1'b1;
            if (extra && cyc == 129) start = 1'b1;
            if (cyc == abort_at) begin
                rst = 1'b1;
                #1;
                check($sformatf("%s_abort", name), {31'd0, write_enable}, 32'd0);
                check($sformatf("%s_abort_cnt", name), {25'd0, cnt_value}, 32'd0);
                check($sformatf("%s_abort_done", name), {31'd0, donee}, 32'd0);
                @(negedge clk);
                rst = 1'b0;
                for (int k = 0; k < 4; k++) begin
                    @(negedge clk);
                    check_idle($sformatf("%s_post_abort_%0d", name, k));
                end
                return;
            end
        end
        if (extra) begin
            @(negedge clk);
            start = 1'b0;
            for (int k = 0; k < 4; k++) begin
                check_idle($sformatf("%s_no_queue_%0d", name, k));
                @(negedge clk);
            end
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst    = 1'b1;
        start  = 1'b0;
        fill_zero();
        repeat (3) @(negedge clk);
        check_idle("reset");
        start = 1'b1;
        @(negedge clk);
        check_idle("reset_start_held");
        start = 1'b0;
        rst   = 1'b0;
        @(negedge clk);
        check_idle("idle");

        fill_zero();
        run_pass("zero", 1'b0, 0, 1'b0);
        @(negedge clk);
        check_idle("zero_after");

        fill_zero();
        mem[0] = 25'h0000001;
        run_pass("lane0", 1'b0, 0, 1'b0);

        fill_zero();
        mem[0] = 25'h0000006;
        run_pass("lane12", 1'b0, 0, 1'b0);

        fill_zero();
        mem[63] = 25'h1000000;
        run_pass("lane24", 1'b0, 0, 1'b0);

        fill_random();
        run_pass("extra_start", 1'b1, 0, 1'b0);

        fill_random();
        run_pass("abort", 1'b0, 100, 1'b0);
        fill_random();
        run_pass("after_abort", 1'b0, 0, 1'b0);

        fill_random();
        run_pass("hold", 1'b0, 0, 1'b1);
        @(negedge clk);
        check_idle("hold_idle");
        @(negedge clk);
        check("hold_restart_cnt0", {25'd0, cnt_value}, 32'd0);
        @(negedge clk);
        check("hold_restart_cnt1", {25'd0, cnt_value}, 32'd1);
        check("hold_restart_we", {31'd0, write_enable}, 32'd0);
        start = 1'b0;
        begin
            int n;
            n = 0;
            while (!donee && n < 300) begin
                @(negedge clk);
                n++;
            end
            check("hold_second_done", {31'd0, donee}, 32'd1);
        end
        @(negedge clk);
        check_idle("hold_end");

        for (int p = 0; p < 3; p++) begin
            fill_random();
            run_pass($sformatf("rand%0d", p), 1'b0, 0, 1'b0);
        end
        @(negedge clk);
        check_idle("final");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
